// File: rtl/spi_regbank_pkg.sv
// Shared types and helpers for the spi_regbank register map: address width
// sizing and address-to-region decode.
package spi_regbank_pkg;

  typedef enum logic [2:0] {
    REGION_CFG,
    REGION_STATUS,
    REGION_IRQ_PEND,
    REGION_IRQ_MASK,
    REGION_NONE
  } region_e;

  // Two extra slots above the config/status window hold IRQ_PEND and IRQ_MASK.
  function automatic int regbank_addr_w(input int num_cfg, input int num_status);
    return $clog2(num_cfg + num_status + 2);
  endfunction

  function automatic region_e addr_region(input int addr, input int num_cfg,
                                          input int num_status);
    if (addr < num_cfg)
      return REGION_CFG;
    else if (addr < num_cfg + num_status)
      return REGION_STATUS;
    else if (addr == num_cfg + num_status)
      return REGION_IRQ_PEND;
    else if (addr == num_cfg + num_status + 1)
      return REGION_IRQ_MASK;
    else
      return REGION_NONE;
  endfunction

endpackage

// File: rtl/spi_regbank_irq.sv
// Sticky rising-edge interrupt block: pending bits cleared by write-1, a mask
// register, and a registered irq output.
module spi_regbank_irq #(
  parameter int NUM_IRQ   = 8,
  parameter int REG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 ena,
  input  logic [NUM_IRQ-1:0]   irq_src,
  input  logic                 wr_pend,
  input  logic                 wr_mask,
  input  logic [NUM_IRQ-1:0]   wdata,
  output logic [REG_WIDTH-1:0] pend_rd,
  output logic [REG_WIDTH-1:0] mask_rd,
  output logic                 irq
);

  logic [NUM_IRQ-1:0] irq_src_q;
  logic [NUM_IRQ-1:0] irq_pending;
  logic [NUM_IRQ-1:0] irq_mask;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;

  assign rise = irq_src & ~irq_src_q;
  assign clr  = wr_pend ? wdata : '0;

  // The rise term is OR'd after the clear so a simultaneous set wins.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      irq_src_q   <= '0;
      irq_pending <= '0;
      irq_mask    <= '0;
      irq         <= 1'b0;
    end else if (ena) begin
      irq_src_q   <= irq_src;
      irq_pending <= (irq_pending & ~clr) | rise;
      if (wr_mask)
        irq_mask <= wdata;
      irq         <= |(irq_pending & irq_mask);
    end
  end

  always_comb begin
    pend_rd = '0;
    mask_rd = '0;
    pend_rd[NUM_IRQ-1:0] = irq_pending;
    mask_rd[NUM_IRQ-1:0] = irq_mask;
  end

endmodule

// File: rtl/spi_regbank.sv
// Register bank behind the spi_reg serial engine: linear map of config,
// status and interrupt registers with per-register write strobes.
module spi_regbank
  import spi_regbank_pkg::*;
#(
  parameter int                          NUM_CFG    = 8,
  parameter int                          NUM_STATUS = 8,
  parameter int                          REG_WIDTH  = 8,
  parameter int                          NUM_IRQ    = 8,
  parameter logic [NUM_CFG*REG_WIDTH-1:0] CFG_RESET = '0,
  localparam int                         ADDR_WIDTH = regbank_addr_w(NUM_CFG, NUM_STATUS)
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            ena,
  input  logic [ADDR_WIDTH-1:0]           reg_addr,
  input  logic [REG_WIDTH-1:0]            reg_data_o,
  input  logic                            reg_data_o_dv,
  output logic [REG_WIDTH-1:0]            reg_data_i,
  output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  output logic [NUM_CFG-1:0]              cfg_wr_stb,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  input  logic [NUM_IRQ-1:0]              irq_src,
  output logic                            irq
);

  region_e                region;
  logic                   wr_en;
  logic                   wr_pend;
  logic                   wr_mask;
  logic [REG_WIDTH-1:0]   pend_rd;
  logic [REG_WIDTH-1:0]   mask_rd;

  assign region  = addr_region(int'(reg_addr), NUM_CFG, NUM_STATUS);
  assign wr_en   = ena & reg_data_o_dv;
  assign wr_pend = wr_en & (region == REGION_IRQ_PEND);
  assign wr_mask = wr_en & (region == REGION_IRQ_MASK);

  // Strobe is registered alongside the data so both appear in the same cycle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      config_regs <= CFG_RESET;
      cfg_wr_stb  <= '0;
    end else begin
      cfg_wr_stb <= '0;
      if (wr_en && region == REGION_CFG) begin
        for (int k = 0; k < NUM_CFG; k++) begin
          if (reg_addr == ADDR_WIDTH'(k)) begin
            config_regs[k*REG_WIDTH +: REG_WIDTH] <= reg_data_o;
            cfg_wr_stb[k]                         <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    reg_data_i = '0;
    case (region)
      REGION_CFG: begin
        for (int k = 0; k < NUM_CFG; k++)
          if (reg_addr == ADDR_WIDTH'(k))
            reg_data_i = config_regs[k*REG_WIDTH +: REG_WIDTH];
      end
      REGION_STATUS: begin
        for (int s = 0; s < NUM_STATUS; s++)
          if (reg_addr == ADDR_WIDTH'(NUM_CFG + s))
            reg_data_i = status_regs[s*REG_WIDTH +: REG_WIDTH];
      end
      REGION_IRQ_PEND: reg_data_i = pend_rd;
      REGION_IRQ_MASK: reg_data_i = mask_rd;
      default:         reg_data_i = '0;
    endcase
  end

  spi_regbank_irq #(
    .NUM_IRQ   (NUM_IRQ),
    .REG_WIDTH (REG_WIDTH)
  ) u_irq (
    .clk     (clk),
    .rstb    (rstb),
    .ena     (ena),
    .irq_src (irq_src),
    .wr_pend (wr_pend),
    .wr_mask (wr_mask),
    .wdata   (reg_data_o[NUM_IRQ-1:0]),
    .pend_rd (pend_rd),
    .mask_rd (mask_rd),
    .irq     (irq)
  );

endmodule

// File: tb/tb_spi_regbank.sv
// Directed bench for spi_regbank with 3 config, 5 status and 8 irq sources.
module tb_spi_regbank;

  localparam int NUM_CFG    = 3;
  localparam int NUM_STATUS = 5;
  localparam int REG_WIDTH  = 8;
  localparam int NUM_IRQ    = 8;
  localparam int ADDR_WIDTH = 4;

  logic                            clk = 1'b0;
  logic                            rstb;
  logic                            ena;
  logic [ADDR_WIDTH-1:0]           reg_addr;
  logic [REG_WIDTH-1:0]            reg_data_o;
  logic                            reg_data_o_dv;
  logic [REG_WIDTH-1:0]            reg_data_i;
  logic [NUM_CFG*REG_WIDTH-1:0]    config_regs;
  logic [NUM_CFG-1:0]              cfg_wr_stb;
  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs;
  logic [NUM_IRQ-1:0]              irq_src;
  logic                            irq;

  int n_chk  = 0;
  int n_fail = 0;

  spi_regbank #(
    .NUM_CFG    (NUM_CFG),
    .NUM_STATUS (NUM_STATUS),
    .REG_WIDTH  (REG_WIDTH),
    .NUM_IRQ    (NUM_IRQ),
    .CFG_RESET  (24'h00A53C)
  ) dut (
    .clk           (clk),
    .rstb          (rstb),
    .ena           (ena),
    .reg_addr      (reg_addr),
    .reg_data_o    (reg_data_o),
    .reg_data_o_dv (reg_data_o_dv),
    .reg_data_i    (reg_data_i),
    .config_regs   (config_regs),
    .cfg_wr_stb    (cfg_wr_stb),
    .status_regs   (status_regs),
    .irq_src       (irq_src),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [ADDR_WIDTH-1:0] a, input logic [REG_WIDTH-1:0] d);
    @(negedge clk);
    reg_addr      = a;
    reg_data_o    = d;
    reg_data_o_dv = 1'b1;
    @(negedge clk);
    reg_data_o_dv = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [ADDR_WIDTH-1:0] a,
                        input logic [REG_WIDTH-1:0] exp);
    reg_addr = a;
    #1;
    check_eq(tag, 32'(reg_data_i), 32'(exp));
  endtask

  initial begin
    rstb          = 1'b0;
    ena           = 1'b1;
    reg_addr      = '0;
    reg_data_o    = '0;
    reg_data_o_dv = 1'b0;
    irq_src       = '0;
    status_regs   = 40'h55_44_33_22_11;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);

    // Reset values
    check_eq("rst_cfg", 32'(config_regs), 32'h00A53C);
    check_eq("rst_stb", 32'(cfg_wr_stb), 32'h0);
    check_eq("rst_irq", 32'(irq), 32'h0);
    rd_chk("rd_cfg1", 4'd1, 8'hA5);
    rd_chk("rst_pend", 4'd8, 8'h00);
    rd_chk("rst_mask", 4'd9, 8'h00);

    // Config write, strobe, status write ignored
    wr(4'd2, 8'h7E);
    check_eq("wr2_cfg", 32'(config_regs), 32'h7EA53C);
    check_eq("wr2_stb", 32'(cfg_wr_stb), 32'h4);
    @(negedge clk);
    check_eq("wr2_stb_off", 32'(cfg_wr_stb), 32'h0);
    wr(4'd4, 8'hFF);
    check_eq("wrst_cfg", 32'(config_regs), 32'h7EA53C);
    check_eq("wrst_stb", 32'(cfg_wr_stb), 32'h0);
    rd_chk("rd_st4", 4'd4, 8'h22);
    rd_chk("rd_st3", 4'd3, 8'h11);
    rd_chk("rd_st7", 4'd7, 8'h55);

    // Back-to-back writes
    @(negedge clk);
    reg_addr = 4'd0; reg_data_o = 8'h11; reg_data_o_dv = 1'b1;
    @(negedge clk);
    check_eq("b2b0_stb", 32'(cfg_wr_stb), 32'h1);
    check_eq("b2b0_cfg", 32'(config_regs), 32'h7EA511);
    reg_addr = 4'd1; reg_data_o = 8'h22;
    @(negedge clk);
    reg_data_o_dv = 1'b0;
    check_eq("b2b1_stb", 32'(cfg_wr_stb), 32'h2);
    check_eq("b2b1_cfg", 32'(config_regs), 32'h7E2211);
    @(negedge clk);
    check_eq("b2b_stb_off", 32'(cfg_wr_stb), 32'h0);

    // Masked pending, unmask, W1C
    irq_src = 8'h04;
    @(negedge clk);
    irq_src = 8'h00;
    rd_chk("pend_set", 4'd8, 8'h04);
    check_eq("irq_masked0", 32'(irq), 32'h0);
    @(negedge clk);
    check_eq("irq_masked1", 32'(irq), 32'h0);
    wr(4'd9, 8'h04);
    check_eq("irq_unmask_lat", 32'(irq), 32'h0);
    @(negedge clk);
    check_eq("irq_unmask", 32'(irq), 32'h1);
    rd_chk("rd_mask", 4'd9, 8'h04);
    wr(4'd8, 8'h04);
    rd_chk("pend_clr", 4'd8, 8'h00);
    check_eq("irq_clr_lat", 32'(irq), 32'h1);
    @(negedge clk);
    check_eq("irq_clr", 32'(irq), 32'h0);

    // Set beats simultaneous clear
    @(negedge clk);
    irq_src = 8'h04; reg_addr = 4'd8; reg_data_o = 8'h04; reg_data_o_dv = 1'b1;
    @(negedge clk);
    reg_data_o_dv = 1'b0; irq_src = 8'h00;
    rd_chk("set_wins", 4'd8, 8'h04);
    @(negedge clk);
    check_eq("set_wins_irq", 32'(irq), 32'h1);
    wr(4'd8, 8'h04);
    wr(4'd9, 8'h00);

    // Held level sets once
    @(negedge clk);
    irq_src = 8'h01;
    @(negedge clk);
    rd_chk("lvl_set", 4'd8, 8'h01);
    wr(4'd8, 8'h01);
    rd_chk("lvl_clr", 4'd8, 8'h00);
    repeat (8) @(negedge clk);
    rd_chk("lvl_hold", 4'd8, 8'h00);
    irq_src = 8'h00;

    // Unmapped address
    rd_chk("rd_unmap10", 4'd10, 8'h00);
    rd_chk("rd_unmap15", 4'd15, 8'h00);
    wr(4'd10, 8'hFF);
    check_eq("wr_unmap_cfg", 32'(config_regs), 32'h7E2211);
    check_eq("wr_unmap_stb", 32'(cfg_wr_stb), 32'h0);
    rd_chk("wr_unmap_pend", 4'd8, 8'h00);
    rd_chk("wr_unmap_mask", 4'd9, 8'h00);

    // Disabled: writes and edges lost
    @(negedge clk);
    ena = 1'b0; reg_addr = 4'd0; reg_data_o = 8'h55; reg_data_o_dv = 1'b1; irq_src = 8'h02;
    @(negedge clk);
    reg_data_o_dv = 1'b0; irq_src = 8'h00;
    check_eq("dis_cfg", 32'(config_regs), 32'h7E2211);
    check_eq("dis_stb", 32'(cfg_wr_stb), 32'h0);
    rd_chk("dis_pend", 4'd8, 8'h00);
    ena = 1'b1;
    @(negedge clk);
    rd_chk("reen_pend", 4'd8, 8'h00);

    // Edge spanning a disabled period is seen on re-enable
    ena = 1'b0; irq_src = 8'h02;
    repeat (2) @(negedge clk);
    rd_chk("span_dis", 4'd8, 8'h00);
    ena = 1'b1;
    @(negedge clk);
    rd_chk("span_reen", 4'd8, 8'h02);

    // Asynchronous reset mid-write
    wr(4'd9, 8'hFF);
    @(negedge clk);
    check_eq("pre_rst_irq", 32'(irq), 32'h1);
    reg_addr = 4'd2; reg_data_o = 8'h99; reg_data_o_dv = 1'b1;
    #2 rstb = 1'b0;
    #1;
    check_eq("arst_cfg", 32'(config_regs), 32'h00A53C);
    check_eq("arst_stb", 32'(cfg_wr_stb), 32'h0);
    check_eq("arst_irq", 32'(irq), 32'h0);
    rd_chk("arst_pend", 4'd8, 8'h00);
    rd_chk("arst_mask", 4'd9, 8'h00);
    @(negedge clk);
    reg_data_o_dv = 1'b0; irq_src = 8'h00;
    check_eq("arst_hold_cfg", 32'(config_regs), 32'h00A53C);
    rstb = 1'b1;
    @(negedge clk);
    check_eq("post_rst_cfg", 32'(config_regs), 32'h00A53C);
    check_eq("post_rst_irq", 32'(irq), 32'h0);
    rd_chk("post_rst_rd2", 4'd2, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_regbank.md
Name: spi_regbank

Overview:
Second-generation register bank that sits behind the existing spi_reg serial engine. It replaces the fixed equal-sized config/status split with an arbitrary-size linear address map. It adds per-register configuration reset values and per-register write strobes. It also adds a sticky, maskable, edge-triggered interrupt block with write-1-to-clear semantics and a registered irq output to the chip top.

Parameters:
- NUM_CFG, 8, number of read/write config registers (>=1)
- NUM_STATUS, 8, number of read-only status registers (>=1, independent of NUM_CFG)
- REG_WIDTH, 8, register width in bits
- NUM_IRQ, 8, number of interrupt sources (1..REG_WIDTH)
- CFG_RESET, all zeros, NUM_CFG*REG_WIDTH bits; reset value of each config register, where register k occupies bits [k*REG_WIDTH +: REG_WIDTH]
- ADDR_WIDTH (localparam), $clog2(NUM_CFG+NUM_STATUS+2)

Ports:
- clk  in  1  system clock
- rstb  in  1  asynchronous, active-low reset
- ena  in  1  block enable; when low, all state is frozen
- reg_addr  in  ADDR_WIDTH  register address from spi_reg
- reg_data_o  in  REG_WIDTH  write data from spi_reg
- reg_data_o_dv  in  1  single-cycle write-valid from spi_reg
- reg_data_i  out  REG_WIDTH  read data to spi_reg (combinational)
- config_regs  out  NUM_CFG*REG_WIDTH  packed config registers, register k at bits [k*REG_WIDTH +: REG_WIDTH]
- cfg_wr_stb  out  NUM_CFG  one-cycle pulse per config register written
- status_regs  in  NUM_STATUS*REG_WIDTH  packed status inputs, same packing as config_regs
- irq_src  in  NUM_IRQ  interrupt sources, synchronous to clk
- irq  out  1  registered interrupt request

Behaviour:
Clocking and reset:
- One clock, clk. Reset rstb is asynchronous and active-low.
- Reset values: config_regs = CFG_RESET; cfg_wr_stb = 0; irq_pending = 0; irq_mask = 0; irq_src_q = 0; irq = 0.
- Reset asserted mid-transaction discards that transaction; no partial write occurs.

Address map:
- [0, NUM_CFG-1]: CFG, read/write
- [NUM_CFG, NUM_CFG+NUM_STATUS-1]: STATUS, read-only
- NUM_CFG+NUM_STATUS: IRQ_PEND; read returns the pending bits, a write clears every bit written as 1
- NUM_CFG+NUM_STATUS+1: IRQ_MASK, read/write
- All other addresses: reads return 0, writes are ignored.
- IRQ register bits at positions >= NUM_IRQ read as 0 and ignore writes.

Read path:
- reg_data_i is a pure combinational decode of reg_addr.
- Read data comes from the current register contents; there is no side effect on read.

Write path (edge with ena=1 and reg_data_o_dv=1):
- CFG k: register k takes reg_data_o at this edge, and cfg_wr_stb[k] is 1 for exactly the following cycle. The strobe is coincident with the new value on config_regs.
- STATUS address: ignored, no strobe.
- Back-to-back dv on consecutive cycles: each write takes effect and each produces its own strobe.

Interrupts:
- irq_src_q registers irq_src every enabled cycle.
- A rise on bit j (irq_src[j]=1 and irq_src_q[j]=0) sets irq_pending[j].
- Pending bits are sticky until cleared through IRQ_PEND.
- If a set and a W1C clear hit the same bit in the same cycle, set wins.
- A level held high sets the pending bit only once.
- irq <= |(irq_pending & irq_mask), so irq is registered. A source edge at cycle n gives pending at n+1 and irq at n+2.
- Unmasking an already pending bit raises irq one cycle after the IRQ_MASK write.

ena = 0:
- No register updates, strobes forced to 0, irq_src_q and irq hold their values.
- dv pulses arriving while ena=0 are lost.
- An edge spanning a disabled period is detected on re-enable only if irq_src_q still differs from irq_src.

Decomposition:
- Package spi_regbank_pkg holds:
  - function regbank_addr_w(num_cfg, num_status)
  - a typedef for the region enum: REGION_CFG, REGION_STATUS, REGION_IRQ_PEND, REGION_IRQ_MASK, REGION_NONE
  - a function decoding an address to a region
- Sub-module spi_regbank_irq holds irq_src_q, irq_pending, irq_mask and the irq output register. Its interface is: wr_pend, wr_mask, wdata, the pending/mask read values, and irq.
- The top level holds the address decode, config storage, strobes and the read mux.

Test Plan:
1. Defaults NUM_CFG=3, NUM_STATUS=5, CFG_RESET={8'h00,8'hA5,8'h3C}: release reset -> config_regs = 24'h00A53C; reading addr 1 returns 8'hA5; irq=0.
2. Write addr 2 = 8'h7E -> config_regs[23:16]=8'h7E one cycle later, cfg_wr_stb=3'b100 for exactly 1 cycle. Write addr 4 (STATUS) = 8'hFF -> no change, no strobe. Reading addr 4 returns status_regs[15:8].
3. Pulse irq_src[2] with IRQ_MASK=8'h00 -> IRQ_PEND=8'h04, irq stays 0. Write IRQ_MASK=8'h04 -> irq=1 the next cycle. W1C IRQ_PEND with 8'h04 -> pending=0, irq falls 1 cycle later.
4. W1C of bit 2 in the same cycle as a new irq_src[2] rise -> IRQ_PEND remains 8'h04.
5. Hold irq_src[0]=1 for 10 cycles, clear it once -> does not re-set. Read addr 10 (unmapped) -> returns 8'h00, and a write to it changes nothing.
6. With ena=0, issue dv writing addr 0 and an irq_src rise -> no state change. Assert rstb low during a write burst -> all outputs return to their reset values immediately (asynchronously).
